// File: rtl/ex_stage_pkg.sv
// Shared pipeline encodings (ALU ops, branch/jump kinds, forward selects) and the EX/MEM register layout.
// Decode and hazard logic import the same constants so that every stage agrees on them.
package ex_stage_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
    } exmem_t;

    // Code 11 is unused by the hazard unit and falls back to the register file value.
    function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                               input logic [31:0] regVal,
                                               input logic [31:0] wbVal,
                                               input logic [31:0] memVal);
        case (sel)
            FWD_WB:  return wbVal;
            FWD_MEM: return memVal;
            default: return regVal;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// 32-bit integer ALU for the execute stage; all arithmetic wraps modulo 2^32.
module alu
    import ex_stage_pkg::*;
(
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  ALUControl,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_ADD:  result = SrcA + SrcB;
            ALU_SUB:  result = SrcA - SrcB;
            ALU_AND:  result = SrcA & SrcB;
            ALU_OR:   result = SrcA | SrcB;
            ALU_XOR:  result = SrcA ^ SrcB;
            ALU_SLT:  result = {31'b0, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: result = {31'b0, SrcA < SrcB};
            ALU_SLL:  result = SrcA << SrcB[4:0];
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register.
// The redirect outputs are purely combinational and ignore clr/rst.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        regWriteE,
    input  logic        memWriteE,
    input  logic        ALUSrcE,
    input  logic        luiE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] extImmE,
    input  logic [4:0]  RdE,
    input  logic [2:0]  ALUControlE,
    input  logic [2:0]  branchE,
    input  logic [1:0]  jumpE,
    input  logic [1:0]  resultSrcE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] ALUResultM_fwd,
    input  logic [31:0] resultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        regWriteM,
    output logic        memWriteM,
    output logic [1:0]  resultSrcM,
    output logic [31:0] ALUResultM,
    output logic [31:0] writeDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  RdM
);

    logic [31:0] srcA;
    logic [31:0] writeData;
    logic [31:0] srcB;
    logic [31:0] aluOut;
    logic [31:0] aluResult;
    logic        branchTaken;
    logic        jumpTaken;
    exmem_t      exmemNext;
    exmem_t      exmem;

    // Forwarding is applied even for x0; the hazard unit is responsible for not requesting it.
    assign srcA      = fwd_select(forwardAE, RD1E, resultW, ALUResultM_fwd);
    assign writeData = fwd_select(forwardBE, RD2E, resultW, ALUResultM_fwd);
    assign srcB      = ALUSrcE ? extImmE : writeData;

    alu u_alu (
        .SrcA       (srcA),
        .SrcB       (srcB),
        .ALUControl (ALUControlE),
        .result     (aluOut)
    );

    assign aluResult = luiE ? extImmE : aluOut;

    always_comb begin
        branchTaken = 1'b0;
        case (branchE)
            BR_BEQ:  branchTaken = (srcA == writeData);
            BR_BNE:  branchTaken = (srcA != writeData);
            BR_BLT:  branchTaken = ($signed(srcA) <  $signed(writeData));
            BR_BGE:  branchTaken = ($signed(srcA) >= $signed(writeData));
            BR_BLTU: branchTaken = (srcA <  writeData);
            BR_BGEU: branchTaken = (srcA >= writeData);
            default: branchTaken = 1'b0;
        endcase
    end

    assign jumpTaken = (jumpE == JMP_JAL) || (jumpE == JMP_JALR);
    assign PCSrcE    = branchTaken || jumpTaken;
    assign PCTargetE = (jumpE == JMP_JALR) ? ((srcA + extImmE) & ~32'd1) : (PCE + extImmE);

    assign exmemNext = '{regWrite:  regWriteE,
                         memWrite:  memWriteE,
                         resultSrc: resultSrcE,
                         aluResult: aluResult,
                         writeData: writeData,
                         pcPlus4:   PCPlus4E,
                         rd:        RdE};

    // clr wins over a normal load so a flushed instruction never reaches MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem <= '0;
        end else if (clr) begin
            exmem <= '0;
        end else begin
            exmem <= exmemNext;
        end
    end

    assign regWriteM  = exmem.regWrite;
    assign memWriteM  = exmem.memWrite;
    assign resultSrcM = exmem.resultSrc;
    assign ALUResultM = exmem.aluResult;
    assign writeDataM = exmem.writeData;
    assign PCPlus4M   = exmem.pcPlus4;
    assign RdM        = exmem.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic against a behavioural model,
// with registered outputs checked through a scoreboard queue popped by an independent monitor.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        regWriteE, memWriteE, ALUSrcE, luiE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, extImmE;
    logic [4:0]  RdE;
    logic [2:0]  ALUControlE, branchE;
    logic [1:0]  jumpE, resultSrcE, forwardAE, forwardBE;
    logic [31:0] ALUResultM_fwd, resultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        regWriteM, memWriteM;
    logic [1:0]  resultSrcM;
    logic [31:0] ALUResultM, writeDataM, PCPlus4M;
    logic [4:0]  RdM;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        clr;
        logic        regWrite, memWrite, aluSrc, lui;
        logic [31:0] rd1, rd2, pc, pcPlus4, imm, aluM, resW;
        logic [4:0]  rd;
        logic [2:0]  aluCtl, branch;
        logic [1:0]  jump, resultSrc, fwdA, fwdB;
    } stim_t;

    typedef struct {
        logic        regWrite, memWrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult, writeData, pcPlus4;
        logic [4:0]  rd;
    } exp_t;

    exp_t expQ[$];

    ex_stage dut (
        .clk(clk), .rst(rst), .clr(clr),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .ALUSrcE(ALUSrcE), .luiE(luiE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .extImmE(extImmE),
        .RdE(RdE), .ALUControlE(ALUControlE), .branchE(branchE), .jumpE(jumpE),
        .resultSrcE(resultSrcE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .ALUResultM_fwd(ALUResultM_fwd), .resultW(resultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
        .ALUResultM(ALUResultM), .writeDataM(writeDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelOperand(input logic [1:0] sel, input logic [31:0] r,
                                                 input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return r;
    endfunction

    function automatic logic [31:0] modelAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return a << (b % 32);
        endcase
    endfunction

    function automatic logic modelBranch(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (br)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return sa < sb;
            3'd4:    return sa >= sb;
            3'd5:    return a < b;
            3'd6:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t zeroStim();
        stim_t s;
        s.clr = 0; s.regWrite = 0; s.memWrite = 0; s.aluSrc = 0; s.lui = 0;
        s.rd1 = 0; s.rd2 = 0; s.pc = 0; s.pcPlus4 = 0; s.imm = 0; s.aluM = 0; s.resW = 0;
        s.rd = 0; s.aluCtl = 0; s.branch = 0; s.jump = 0; s.resultSrc = 0; s.fwdA = 0; s.fwdB = 0;
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s.clr = ($urandom_range(0, 7) == 0);
        s.regWrite = $urandom; s.memWrite = $urandom; s.aluSrc = $urandom; s.lui = ($urandom_range(0, 5) == 0);
        s.rd1 = $urandom; s.pc = $urandom; s.pcPlus4 = $urandom; s.imm = $urandom;
        s.aluM = $urandom; s.resW = $urandom;
        s.rd2 = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
        s.rd = $urandom; s.aluCtl = $urandom; s.branch = $urandom; s.jump = $urandom;
        s.resultSrc = $urandom; s.fwdA = $urandom; s.fwdB = $urandom;
        return s;
    endfunction

    // Drives one instruction at the falling edge, queues its EX/MEM image and checks the redirect outputs.
    task automatic applyStimulus(input stim_t s);
        logic [31:0] a, wd, b, res, target;
        logic        taken;
        exp_t        e;
        @(negedge clk);
        clr = s.clr; regWriteE = s.regWrite; memWriteE = s.memWrite; ALUSrcE = s.aluSrc; luiE = s.lui;
        RD1E = s.rd1; RD2E = s.rd2; PCE = s.pc; PCPlus4E = s.pcPlus4; extImmE = s.imm;
        RdE = s.rd; ALUControlE = s.aluCtl; branchE = s.branch; jumpE = s.jump;
        resultSrcE = s.resultSrc; forwardAE = s.fwdA; forwardBE = s.fwdB;
        ALUResultM_fwd = s.aluM; resultW = s.resW;

        a      = modelOperand(s.fwdA, s.rd1, s.resW, s.aluM);
        wd     = modelOperand(s.fwdB, s.rd2, s.resW, s.aluM);
        b      = s.aluSrc ? s.imm : wd;
        res    = s.lui ? s.imm : modelAlu(s.aluCtl, a, b);
        taken  = modelBranch(s.branch, a, wd) || s.jump == 2'd1 || s.jump == 2'd2;
        target = (s.jump == 2'd2) ? ((a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);

        if (s.clr) e = '{1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0};
        else       e = '{s.regWrite, s.memWrite, s.resultSrc, res, wd, s.pcPlus4, s.rd};
        expQ.push_back(e);

        #1;
        checkOutput("PCSrcE", {31'b0, PCSrcE}, {31'b0, taken});
        checkOutput("PCTargetE", PCTargetE, target);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_regWriteM"}, {31'b0, regWriteM}, 32'd0);
        checkOutput({tag, "_memWriteM"}, {31'b0, memWriteM}, 32'd0);
        checkOutput({tag, "_resultSrcM"}, {30'b0, resultSrcM}, 32'd0);
        checkOutput({tag, "_ALUResultM"}, ALUResultM, 32'd0);
        checkOutput({tag, "_writeDataM"}, writeDataM, 32'd0);
        checkOutput({tag, "_PCPlus4M"}, PCPlus4M, 32'd0);
        checkOutput({tag, "_RdM"}, {27'b0, RdM}, 32'd0);
    endtask

    // Monitor: one queued instruction lands in EX/MEM at each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_regWriteM", {31'b0, regWriteM}, {31'b0, e.regWrite});
                checkOutput("sb_memWriteM", {31'b0, memWriteM}, {31'b0, e.memWrite});
                checkOutput("sb_resultSrcM", {30'b0, resultSrcM}, {30'b0, e.resultSrc});
                checkOutput("sb_ALUResultM", ALUResultM, e.aluResult);
                checkOutput("sb_writeDataM", writeDataM, e.writeData);
                checkOutput("sb_PCPlus4M", PCPlus4M, e.pcPlus4);
                checkOutput("sb_RdM", {27'b0, RdM}, {27'b0, e.rd});
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; clr = 1'b0;
        regWriteE = 1; memWriteE = 1; ALUSrcE = 0; luiE = 0;
        RD1E = 32'h11; RD2E = 32'h22; PCE = 32'h100; PCPlus4E = 32'h104; extImmE = 32'h8;
        RdE = 5'd9; ALUControlE = 3'd0; branchE = 3'd0; jumpE = 2'd0; resultSrcE = 2'd1;
        forwardAE = 2'd0; forwardBE = 2'd0; ALUResultM_fwd = 32'h0; resultW = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        s = zeroStim(); s.rd1 = 5; s.rd2 = 7; s.rd = 5'd3; s.regWrite = 1; s.pcPlus4 = 32'h24;
        applyStimulus(s);
        checkOutput("add_PCSrcE", {31'b0, PCSrcE}, 32'd0);
        @(posedge clk); #2;
        checkOutput("add_ALUResultM", ALUResultM, 32'd12);

        s = zeroStim(); s.fwdA = 2'b10; s.aluM = 32'd100; s.rd1 = 32'd55; s.imm = 32'hFFFF_FFFC; s.aluSrc = 1;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("memfwd_ALUResultM", ALUResultM, 32'd96);

        s = zeroStim(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.branch = 3'b011; s.pc = 32'h40; s.imm = 32'h10;
        applyStimulus(s);
        checkOutput("blt_PCSrcE", {31'b0, PCSrcE}, 32'd1);
        checkOutput("blt_PCTargetE", PCTargetE, 32'h50);
        s.branch = 3'b101;
        applyStimulus(s);
        checkOutput("bltu_PCSrcE", {31'b0, PCSrcE}, 32'd0);

        s = zeroStim(); s.rd1 = 32'h103; s.imm = 32'h4; s.jump = 2'b10; s.pc = 32'h800; s.pcPlus4 = 32'h804;
        applyStimulus(s);
        checkOutput("jalr_PCTargetE", PCTargetE, 32'h106);
        checkOutput("jalr_PCSrcE", {31'b0, PCSrcE}, 32'd1);
        @(posedge clk); #2;
        checkOutput("jalr_PCPlus4M", PCPlus4M, 32'h804);

        s = zeroStim(); s.lui = 1; s.imm = 32'h1234_5000; s.aluCtl = 3'b001; s.rd1 = 32'h777;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("lui_ALUResultM", ALUResultM, 32'h1234_5000);

        s = zeroStim(); s.clr = 1; s.regWrite = 1; s.memWrite = 1; s.rd1 = 32'h5; s.rd = 5'd7;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("clr_regWriteM", {31'b0, regWriteM}, 32'd0);
        checkOutput("clr_memWriteM", {31'b0, memWriteM}, 32'd0);

        for (int i = 0; i < 300; i++) applyStimulus(randomStim());

        s = zeroStim(); s.regWrite = 1; s.memWrite = 1; s.resultSrc = 2'd2; s.rd1 = 32'hAB;
        s.rd2 = 32'hCD; s.pcPlus4 = 32'h44; s.rd = 5'd31;
        applyStimulus(s);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkAllZero("rst_pulse");
        #1 rst = 1'b0;

        for (int i = 0; i < 50; i++) applyStimulus(randomStim());

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have clr in 1: synchronous flush of the EX/MEM register.
REQ-004 SHALL have these ID/EX-side inputs: regWriteE, memWriteE, ALUSrcE, luiE (1 each); RD1E, RD2E, PCE, PCPlus4E, extImmE (32 each); RdE 5; ALUControlE 3; branchE 3; jumpE 2; resultSrcE 2.
REQ-005 SHALL have forwarding inputs: forwardAE, forwardBE (2 each); ALUResultM_fwd, resultW (32 each).
REQ-006 SHALL have redirect outputs: PCSrcE 1 (taken branch/jump); PCTargetE 32.
REQ-007 SHALL have EX/MEM outputs: regWriteM, memWriteM (1 each); resultSrcM 2; ALUResultM, writeDataM, PCPlus4M (32 each); RdM 5.

Function
REQ-008 SHALL select SrcA from forwardAE: 00 RD1E; 01 resultW; 10 ALUResultM_fwd; 11 RD1E.
REQ-009 SHALL select writeData from forwardBE with the same encoding applied to RD2E.
REQ-010 SHALL use SrcB = extImmE when ALUSrcE=1, else writeData.
REQ-011 SHALL decode ALUControlE: 000 add; 001 sub; 010 and; 011 or; 100 xor; 101 slt (signed, 0/1); 110 sltu (0/1); 111 sll by SrcB[4:0].
REQ-012 SHALL make arithmetic 32-bit modulo 2^32, with no overflow flag.
REQ-013 SHALL make the ALU result extImmE when luiE=1, regardless of ALUControlE.
REQ-014 SHALL evaluate the branch condition on SrcA vs writeData, using branchE: 000 none; 001 beq; 010 bne; 011 blt; 100 bge; 101 bltu; 110 bgeu; 111 none.
REQ-015 SHALL decode jumpE: 00 none; 01 jal; 10 jalr; 11 none.
REQ-016 SHALL assert PCSrcE combinationally, in the same cycle, when the branch condition is true or jumpE is 01 or 10.
REQ-017 SHALL drive PCTargetE as (SrcA + extImmE) with bit0 cleared for jalr, else PCE + extImmE; it is valid every cycle.
REQ-018 SHALL register ALU result, writeData, RdE, PCPlus4E, regWriteE, memWriteE and resultSrcE into the EX/MEM register on each rising clk, with latency exactly 1 cycle.
REQ-019 SHALL give clr priority over load: when clr=1 at an edge, all EX/MEM outputs become 0 and the inputs of that cycle are dropped.
REQ-020 SHALL leave PCSrcE/PCTargetE unaffected by clr and rst; they are purely combinational from the current inputs.
REQ-021 SHALL let the forwarding inputs override RD1E/RD2E even when RdM or RdW is x0; suppressing forwarding from x0 is the hazard unit's job.

Reset
REQ-022 SHALL clear every EX/MEM output to 0 asynchronously on rst=1, independent of clk.
REQ-023 SHALL hold those outputs at 0 while rst=1; the first load occurs on the first rising clk after rst deasserts.
REQ-024 SHALL treat a rst assertion mid-operation as discarding the in-flight EX/MEM contents; no partial state is retained.

Structure
REQ-025 SHALL take the ALUControl, branch, jump and forward-select encodings as named constants from the shared pipeline package used by decode and hazard logic.
REQ-026 SHALL implement the ALU as the sub-module alu (inputs SrcA, SrcB, ALUControl; output result).
REQ-027 SHALL keep the forwarding muxes, branch compare, target adder and EX/MEM register in ex_stage.

Verification
REQ-028 SHALL cover add forwarding: RD1E=5, RD2E=7, forward 00/00, ALUControlE=000, ALUSrcE=0 -> ALUResultM=12 one edge later, PCSrcE=0.
REQ-029 SHALL cover MEM forwarding: forwardAE=10, ALUResultM_fwd=100, extImmE=-4, ALUSrcE=1, add -> ALUResultM=96.
REQ-030 SHALL cover a taken blt: SrcA=0xFFFFFFFF, writeData=1, branchE=011, PCE=0x40, extImmE=0x10 -> PCSrcE=1, PCTargetE=0x50; with bltu (101) -> PCSrcE=0.
REQ-031 SHALL cover jalr: SrcA=0x103, extImmE=0x4, jumpE=10 -> PCTargetE=0x106, PCSrcE=1, PCPlus4M=PCPlus4E after the edge.
REQ-032 SHALL cover lui: luiE=1, extImmE=0x12345000, ALUControlE=001 -> ALUResultM=0x12345000.
REQ-033 SHALL cover clr and reset: clr=1 with regWriteE=1, memWriteE=1 -> both outputs 0 after the edge; rst pulsed between edges -> all EX/MEM outputs 0 immediately.
